// File: rtl/pipe_muldiv_unit_if.sv
// Request/response bundle between the EXE stage and the iterative multiply/divide unit.
// The master side issues operations; the slave side (the unit) returns results and stall.
interface pipe_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic             stall;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, hi, lo, div_zero, stall
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, hi, lo, div_zero, stall
  );
endinterface

// File: rtl/pipe_muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide sharing one 2*WIDTH shift register.
// One bit per cycle on operand magnitudes; sign correction and special cases applied in StFix.
module pipe_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic               clk,
  input logic               rst,
  pipe_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic               b_zero_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_val;
  logic [WIDTH-1:0]   rem_val;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dz;

  assign accept = bus.start & ~bus.abort & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    a_neg   = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg   = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag   = a_neg ? -bus.a : bus.a;
    b_mag   = b_neg ? -bus.b : bus.b;

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, shift right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);

    // Divide: shift {rem, dividend} left, keep the trial subtraction when it does not borrow.
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_mag_q};

    if (op_q[1]) begin
      acc_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod    = neg_q_q ? -acc_q : acc_q;
    quo_val = acc_q[WIDTH-1:0];
    rem_val = acc_q[2*WIDTH-1:WIDTH];

    // With b==0 the remainder path rebuilds |a| and re-applies a's sign, so hi equals a.
    // Most-negative / -1 needs no special handling: |a| / 1 with both signs negative.
    if (op_q[1]) begin
      fix_hi = neg_r_q ? -rem_val : rem_val;
      fix_lo = b_zero_q ? '1 : (neg_q_q ? -quo_val : quo_val);
      fix_dz = b_zero_q;
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      fix_dz = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      b_mag_q    <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      b_zero_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (accept) begin
            op_q     <= bus.op;
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            b_mag_q  <= b_mag;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            b_zero_q <= (bus.b == '0);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StBusy;
          end else begin
            state_q  <= StIdle;
          end
        end
        StBusy: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          busy_q <= 1'b0;
          if (bus.abort) begin
            state_q <= StIdle;
          end else begin
            hi_q       <= fix_hi;
            lo_q       <= fix_lo;
            div_zero_q <= fix_dz;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;
  assign bus.stall    = busy_q | accept;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Directed bench for pipe_muldiv_unit: expected results queued at issue, checked by a monitor
// whenever done is seen, alongside direct checks of reset, stall, handshake and abort.
module tb_pipe_muldiv_unit;
  localparam int unsigned W = 32;
  // done is seen this many edges after the accepting edge
  localparam int Lat = W + 1;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_muldiv_unit_if #(.WIDTH(W)) bus ();

  pipe_muldiv_unit #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, " hi"}, 64'(bus.hi), 64'(e.hi));
        check({e.name, " lo"}, 64'(bus.lo), 64'(e.lo));
        check({e.name, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
        check({e.name, " latency"}, 64'(cyc - last_acc), 64'(Lat));
      end
    end
    // busy rising marks the edge that accepted the op
    if (!rst && bus.busy && !prev_busy) last_acc = cyc;
    prev_busy = bus.busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic expect_res(input string name, input logic [W-1:0] h, input logic [W-1:0] l,
                            input logic dz);
    exp_t e;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    e.dz   = dz;
    exp_q.push_back(e);
  endtask

  // Call just after a posedge; start is held for exactly one edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'hdead_beef;
    bus.b     = 32'h1234_5678;
    bus.op    = ~o;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    if (!got) check({name, " done timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] h, input logic [W-1:0] l,
                     input logic dz);
    idle(1);
    expect_res(name, h, l, dz);
    issue(o, x, y);
    wait_done(name);
  endtask

  initial begin
    int n_st;
    bit got;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    rst = 1'b0;

    // Reset mid-operation clears a prior result and the in-flight op
    run("multu 3*5", OpMultu, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    idle(1);
    issue(OpMultu, 32'd7, 32'd9);
    idle(9);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid-op reset busy", 64'(bus.busy), 64'd0);
    check("mid-op reset done", 64'(bus.done), 64'd0);
    check("mid-op reset hi", 64'(bus.hi), 64'd0);
    check("mid-op reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Multiply
    run("mult -1*2", OpMult, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run("multu ffffffff*2", OpMultu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run("mult -3*-5", OpMult, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0);
    run("mult min*min", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);

    // Divide
    run("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run("divu fffffff9/2", OpDivu, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);

    // Special cases
    run("divu 7/0", OpDivu, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    idle(5);
    @(negedge clk);
    check("div_zero held", 64'(bus.div_zero), 64'd1);
    check("hi held", 64'(bus.hi), 64'd7);
    run("div -7/0", OpDiv, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run("div min/-1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // start held high through BUSY: operands sampled once, single op
    idle(1);
    expect_res("held start divu 100/7", 32'd2, 32'd14, 1'b0);
    bus.op    = OpDivu;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 32'd1;
    bus.b = 32'd1;
    idle(20);
    bus.start = 1'b0;
    wait_done("held start");
    repeat (40) @(negedge clk);

    // Stall window, then back-to-back start in the DONE cycle
    idle(1);
    expect_res("multu 6*7", 32'd0, 32'd42, 1'b0);
    bus.op    = OpMultu;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    check("stall in accept cycle", 64'(bus.stall), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_st = 0;
    got  = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1;
      else if (bus.stall) n_st++;
    end
    check("stall busy cycles", 64'(n_st), 64'(W + 1));
    check("stall in done cycle", 64'(bus.stall), 64'd0);
    expect_res("b2b div -100/7", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    bus.op    = OpDiv;
    bus.a     = 32'hFFFF_FF9C;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    #1;
    check("stall on b2b accept", 64'(bus.stall), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b no idle bubble", 64'(bus.busy), 64'd1);
    wait_done("b2b");

    // Abort in BUSY cycle 5
    idle(2);
    issue(OpMultu, 32'h0001_2345, 32'h0000_6789);
    idle(5);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort stall", 64'(bus.stall), 64'd0);
    check("abort hi kept", 64'(bus.hi), 64'hFFFF_FFFE);
    check("abort lo kept", 64'(bus.lo), 64'hFFFF_FFF2);
    repeat (40) @(negedge clk);

    // Abort in FIX (after the last iteration edge)
    idle(1);
    issue(OpMultu, 32'd11, 32'd13);
    idle(W);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("fix abort done", 64'(bus.done), 64'd0);
    check("fix abort busy", 64'(bus.busy), 64'd0);
    check("fix abort lo kept", 64'(bus.lo), 64'hFFFF_FFF2);
    repeat (40) @(negedge clk);

    // start together with abort in IDLE is dropped
    idle(1);
    bus.op    = OpMultu;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("start+abort stall", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("start+abort busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);

    check("pending expectations", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
